// File: rtl/fptd_iter_ctrl.sv
// Iteration controller for one upper/lower razor decoder pair of the fully
// parallel turbo decoder. It sequences the term/odd/even half-iterations,
// replays a half-iteration when razor flags fire, stops early once the hard
// decisions settle, and keeps per-frame and accumulated error statistics.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for Start
// S_TERM     | termination update strobe
// S_ODD      | odd half-iteration strobe
// S_ODD_CHK  | razor check of the odd half: replay it or move on
// S_EVEN     | even half-iteration strobe
// S_EVEN_CHK | razor check of the even half; closes a full iteration
// S_COUNT    | error counter strobe, statistics captured
// S_DONE     | one-cycle end-of-frame pulse
module fptd_iter_ctrl #(
  parameter int FL           = 104,
  parameter int MAX_ITER     = 8,
  parameter int STABLE_ITERS = 2,
  parameter int REPLAY_MAX   = 3,
  parameter int RAZOR_EN     = 1,
  parameter int EARLY_STOP   = 1,
  parameter int CW           = 7,
  parameter int AW           = 16
) (
  input  logic                              Clock,
  input  logic                              nReset,
  input  logic                              nClear,
  input  logic                              Start,
  input  logic                              Razor_Error,
  input  logic [FL-1:0]                     Hard_Dec,
  input  logic [FL-1:0]                     b1_error,
  output logic                              Enable_Term,
  output logic                              Enable_Odd,
  output logic                              Enable_Even,
  output logic                              Enable_Error_Counter,
  output logic                              Busy,
  output logic                              Done,
  output logic [$clog2(MAX_ITER+1)-1:0]     Iter_Count,
  output logic                              Early_Stop,
  output logic [CW-1:0]                     Frame_Errors,
  output logic [AW-1:0]                     Error_Total,
  output logic [AW-1:0]                     Replay_Total,
  output logic                              Razor_Fail
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = $clog2(STABLE_ITERS + 1);
  localparam int RW = (REPLAY_MAX > 0) ? $clog2(REPLAY_MAX + 1) : 1;
  localparam logic [31:0] FE_MAX = (32'd1 << CW) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_TERM, S_ODD, S_ODD_CHK, S_EVEN, S_EVEN_CHK, S_COUNT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic            prev_valid_q, prev_valid_d;
  logic [FL-1:0]   prev_dec_q, prev_dec_d;
  logic [RW-1:0]   replay_q, replay_d;
  logic            early_q, early_d;
  logic [CW-1:0]   frame_err_q, frame_err_d;
  logic [AW-1:0]   err_total_q, err_total_d;
  logic [AW-1:0]   replay_total_q, replay_total_d;
  logic            razor_fail_q, razor_fail_d;

  logic [31:0]     pop;
  logic [CW-1:0]   fe_sat;
  logic [AW:0]     err_sum;
  logic [IW-1:0]   iter_inc;
  logic [SW-1:0]   stab_nxt;
  logic            replay_take;

  // Popcount of the error flags, clipped to the frame counter width, and the
  // saturating accumulation into the running total.
  always_comb begin
    pop = '0;
    for (int i = 0; i < FL; i++) begin
      pop = pop + 32'(b1_error[i]);
    end
    fe_sat  = (pop > FE_MAX) ? {CW{1'b1}} : pop[CW-1:0];
    err_sum = {1'b0, err_total_q} + {{(AW + 1 - CW){1'b0}}, fe_sat};
  end

  // Next-state, strobes and register updates; a low nClear overrides all.
  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    stab_d         = stab_q;
    prev_valid_d   = prev_valid_q;
    prev_dec_d     = prev_dec_q;
    replay_d       = replay_q;
    early_d        = early_q;
    frame_err_d    = frame_err_q;
    err_total_d    = err_total_q;
    replay_total_d = replay_total_q;
    razor_fail_d   = razor_fail_q;
    Enable_Term          = 1'b0;
    Enable_Odd           = 1'b0;
    Enable_Even          = 1'b0;
    Enable_Error_Counter = 1'b0;

    iter_inc    = iter_q + 1'b1;
    replay_take = (RAZOR_EN != 0) && Razor_Error && (replay_q < RW'(REPLAY_MAX));
    if (prev_valid_q && (Hard_Dec == prev_dec_q)) begin
      // Saturate so the counter cannot wrap when early stop is disabled.
      stab_nxt = (stab_q == SW'(STABLE_ITERS)) ? stab_q : stab_q + 1'b1;
    end else begin
      stab_nxt = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d      = S_TERM;
          iter_d       = '0;
          stab_d       = '0;
          prev_valid_d = 1'b0;
          replay_d     = '0;
          early_d      = 1'b0;
        end
      end
      S_TERM: begin
        Enable_Term = 1'b1;
        state_d     = S_ODD;
      end
      S_ODD: begin
        Enable_Odd = 1'b1;
        state_d    = S_ODD_CHK;
      end
      S_EVEN: begin
        Enable_Even = 1'b1;
        state_d     = S_EVEN_CHK;
      end
      S_ODD_CHK, S_EVEN_CHK: begin
        if (replay_take) begin
          replay_d = replay_q + 1'b1;
          if (!(&replay_total_q)) replay_total_d = replay_total_q + 1'b1;
          state_d = (state_q == S_ODD_CHK) ? S_ODD : S_EVEN;
        end else begin
          // Razor still high here means the replay budget ran out.
          if (Razor_Error) razor_fail_d = 1'b1;
          replay_d = '0;
          if (state_q == S_ODD_CHK) begin
            state_d = S_EVEN;
          end else begin
            iter_d       = iter_inc;
            stab_d       = stab_nxt;
            prev_dec_d   = Hard_Dec;
            prev_valid_d = 1'b1;
            if (iter_inc == IW'(MAX_ITER)) begin
              state_d = S_COUNT;
            end else if ((EARLY_STOP != 0) && (stab_nxt >= SW'(STABLE_ITERS))) begin
              state_d = S_COUNT;
              early_d = 1'b1;
            end else begin
              state_d = S_ODD;
            end
          end
        end
      end
      S_COUNT: begin
        Enable_Error_Counter = 1'b1;
        frame_err_d = fe_sat;
        err_total_d = err_sum[AW] ? {AW{1'b1}} : err_sum[AW-1:0];
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!nClear) begin
      state_d        = S_IDLE;
      iter_d         = '0;
      stab_d         = '0;
      prev_valid_d   = 1'b0;
      prev_dec_d     = '0;
      replay_d       = '0;
      early_d        = 1'b0;
      frame_err_d    = '0;
      err_total_d    = '0;
      replay_total_d = '0;
      razor_fail_d   = 1'b0;
    end
  end

  // State and statistics registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q        <= S_IDLE;
      iter_q         <= '0;
      stab_q         <= '0;
      prev_valid_q   <= 1'b0;
      prev_dec_q     <= '0;
      replay_q       <= '0;
      early_q        <= 1'b0;
      frame_err_q    <= '0;
      err_total_q    <= '0;
      replay_total_q <= '0;
      razor_fail_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      stab_q         <= stab_d;
      prev_valid_q   <= prev_valid_d;
      prev_dec_q     <= prev_dec_d;
      replay_q       <= replay_d;
      early_q        <= early_d;
      frame_err_q    <= frame_err_d;
      err_total_q    <= err_total_d;
      replay_total_q <= replay_total_d;
      razor_fail_q   <= razor_fail_d;
    end
  end

  assign Busy         = (state_q != S_IDLE);
  assign Done         = (state_q == S_DONE);
  assign Iter_Count   = iter_q;
  assign Early_Stop   = early_q;
  assign Frame_Errors = frame_err_q;
  assign Error_Total  = err_total_q;
  assign Replay_Total = replay_total_q;
  assign Razor_Fail   = razor_fail_q;

endmodule

// File: tb/tb_fptd_iter_ctrl.sv
// Scoreboard bench for fptd_iter_ctrl: frames are launched with hand-computed
// expectations pushed into per-instance queues; monitors pop them on Done.
// Instance 0 uses default parameters, instance 1 uses MAX_ITER=1 and AW=7.
module tb_fptd_iter_ctrl;
  localparam int FL = 104;
  localparam int M_CHANGE = 0;
  localparam int M_STABLE = 1;
  localparam int M_RONCE  = 2;
  localparam int M_RALL   = 3;

  typedef struct {
    int t_done;
    int iter;
    int es;
    int fe;
    int et;
    int rt;
    int rf;
  } exp_t;

  logic Clock, nReset, nClear, start0, start1, Razor_Error;
  logic [FL-1:0] Hard_Dec, b1;
  logic [FL-1:0] stable_val;
  logic [127:0]  hd_rand;

  logic en_t0, en_o0, en_e0, en_c0, busy0, done0, es0, rf0;
  logic [3:0]  iter0;
  logic [6:0]  fe0;
  logic [15:0] et0, rt0;

  logic en_t1, en_o1, en_e1, en_c1, busy1, done1, es1, rf1;
  logic [0:0]  iter1;
  logic [6:0]  fe1;
  logic [6:0]  et1, rt1;

  int cyc = 0;
  int t0 = 0;
  int mode = M_CHANGE;
  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  fptd_iter_ctrl u_dut0 (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Start(start0),
    .Razor_Error(Razor_Error), .Hard_Dec(Hard_Dec), .b1_error(b1),
    .Enable_Term(en_t0), .Enable_Odd(en_o0), .Enable_Even(en_e0),
    .Enable_Error_Counter(en_c0), .Busy(busy0), .Done(done0),
    .Iter_Count(iter0), .Early_Stop(es0), .Frame_Errors(fe0),
    .Error_Total(et0), .Replay_Total(rt0), .Razor_Fail(rf0)
  );

  fptd_iter_ctrl #(.MAX_ITER(1), .AW(7)) u_dut1 (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Start(start1),
    .Razor_Error(Razor_Error), .Hard_Dec(Hard_Dec), .b1_error(b1),
    .Enable_Term(en_t1), .Enable_Odd(en_o1), .Enable_Even(en_e1),
    .Enable_Error_Counter(en_c1), .Busy(busy1), .Done(done1),
    .Iter_Count(iter1), .Early_Stop(es1), .Frame_Errors(fe1),
    .Error_Total(et1), .Replay_Total(rt1), .Razor_Fail(rf1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Input driver: Hard_Dec and Razor_Error follow the current frame mode.
  always @(negedge Clock) begin
    hd_rand = {$urandom(), $urandom(), $urandom(), $urandom()};
    Hard_Dec = (mode == M_STABLE) ? stable_val : hd_rand[FL-1:0];
    Razor_Error = (mode == M_RALL) || ((mode == M_RONCE) && ((cyc - t0) == 3));
  end

  // Monitor for instance 0.
  always @(negedge Clock) begin
    exp_t e0;
    if (nReset && done0) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected_done", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 done_cycle", cyc, e0.t_done);
        chk("dut0 iter_count", int'(iter0), e0.iter);
        chk("dut0 early_stop", int'(es0), e0.es);
        chk("dut0 frame_errors", int'(fe0), e0.fe);
        chk("dut0 error_total", int'(et0), e0.et);
        chk("dut0 replay_total", int'(rt0), e0.rt);
        chk("dut0 razor_fail", int'(rf0), e0.rf);
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge Clock) begin
    exp_t e1;
    if (nReset && done1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 done_cycle", cyc, e1.t_done);
        chk("dut1 iter_count", int'(iter1), e1.iter);
        chk("dut1 early_stop", int'(es1), e1.es);
        chk("dut1 frame_errors", int'(fe1), e1.fe);
        chk("dut1 error_total", int'(et1), e1.et);
        chk("dut1 replay_total", int'(rt1), e1.rt);
        chk("dut1 razor_fail", int'(rf1), e1.rf);
      end
    end
  end

  // Strobe exclusivity on both instances, and odd replay timing.
  always @(negedge Clock) begin
    if (nReset) begin
      chk("dut0 onehot_enables", int'(en_t0) + int'(en_o0) + int'(en_e0) + int'(en_c0) <= 1, 1);
      chk("dut1 onehot_enables", int'(en_t1) + int'(en_o1) + int'(en_e1) + int'(en_c1) <= 1, 1);
      if (mode == M_RONCE && busy0) begin
        if ((cyc - t0) == 2 || (cyc - t0) == 4) chk("ronce odd_pulse", int'(en_o0), 1);
        if ((cyc - t0) == 3) chk("ronce odd_gap", int'(en_o0), 0);
      end
    end
  end

  task automatic run_frame(input bit which, input int md, input logic [FL-1:0] b1v,
                           input int rel_done, input int iter, input int es,
                           input int fe, input int et, input int rt, input int rf);
    exp_t e;
    bit seen;
    @(negedge Clock);
    mode = md;
    b1 = b1v;
    t0 = cyc;
    e.t_done = cyc + rel_done;
    e.iter = iter; e.es = es; e.fe = fe; e.et = et; e.rt = rt; e.rf = rf;
    if (which) begin q1.push_back(e); start1 = 1'b1; end
    else begin q0.push_back(e); start0 = 1'b1; end
    @(negedge Clock);
    start0 = 1'b0;
    start1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge Clock);
      // A stray Start mid-frame must be ignored.
      start0 = (!which && (cyc - t0) == 20);
      seen = which ? done1 : done0;
    end
    start0 = 1'b0;
    if (!seen) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    logic [FL-1:0] b_five, b_three, b_none, b_all;
    b_none = '0;
    b_all  = '1;
    b_five = '0;
    b_five[0] = 1'b1; b_five[17] = 1'b1; b_five[50] = 1'b1; b_five[77] = 1'b1; b_five[103] = 1'b1;
    b_three = '0;
    b_three[1] = 1'b1; b_three[2] = 1'b1; b_three[99] = 1'b1;
    stable_val = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 8'hA5};

    nReset = 1'b0; nClear = 1'b1; start0 = 1'b0; start1 = 1'b0; b1 = '0;
    Razor_Error = 1'b0; Hard_Dec = '0;
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset iter", int'(iter0), 0);
    chk("reset enables", int'(en_t0 | en_o0 | en_e0 | en_c0), 0);
    chk("reset error_total", int'(et0), 0);
    chk("reset razor_fail", int'(rf0), 0);
    chk("reset dut1 busy", int'(busy1), 0);
    chk("reset dut1 replay_total", int'(rt1), 0);

    // Full 8 iterations, decisions keep changing.
    run_frame(0, M_CHANGE, b_five, 35, 8, 0, 5, 5, 0, 0);
    // Constant decisions: stable after iteration 3.
    run_frame(0, M_STABLE, b_none, 15, 3, 1, 0, 5, 0, 0);
    // One replay of the first odd half.
    run_frame(0, M_RONCE, b_three, 37, 8, 0, 3, 8, 1, 0);

    // Abort a frame with nClear at cycle 10; no Done may follow.
    @(negedge Clock);
    mode = M_CHANGE; t0 = cyc; start0 = 1'b1;
    @(negedge Clock);
    start0 = 1'b0;
    repeat (9) @(negedge Clock);
    nClear = 1'b0;
    @(negedge Clock);
    chk("clear busy", int'(busy0), 0);
    chk("clear iter", int'(iter0), 0);
    chk("clear error_total", int'(et0), 0);
    chk("clear replay_total", int'(rt0), 0);
    chk("clear frame_errors", int'(fe0), 0);
    chk("clear done", int'(done0), 0);
    nClear = 1'b1;

    // Fresh frame at cycle 12, then a back-to-back frame.
    run_frame(0, M_CHANGE, b_all, 35, 8, 0, 104, 104, 0, 0);
    run_frame(0, M_CHANGE, b_all, 35, 8, 0, 104, 208, 0, 0);

    // MAX_ITER=1 instance: razor stuck high, then saturating 7-bit total.
    run_frame(1, M_RALL, b_none, 19, 1, 0, 0, 0, 6, 1);
    run_frame(1, M_CHANGE, b_all, 7, 1, 0, 104, 104, 6, 1);
    run_frame(1, M_CHANGE, b_all, 7, 1, 0, 104, 127, 6, 1);

    repeat (5) @(negedge Clock);
    chk("dut0 pending_expectations", q0.size(), 0);
    chk("dut1 pending_expectations", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fptd_iter_ctrl.md
# fptd_iter_ctrl

Parametrised iteration controller for the fully parallel turbo decoder. It generates the Enable_Term, Enable_Odd, Enable_Even and Enable_Error_Counter strobes that drive the upper and lower razor decoder arrays. It adds razor-triggered half-iteration replay, early termination on stable hard decisions, and frame and accumulated error statistics. It sits between the frame loader and both decoder arrays, one instance per decoder pair.

## Interface

Parameters:
- FL, 104, frame length in bits.
- MAX_ITER, 8, maximum full iterations per frame (≥1).
- STABLE_ITERS, 2, consecutive unchanged-hard-decision iterations that trigger early stop (≥1).
- REPLAY_MAX, 3, maximum consecutive replays of one half-iteration.
- RAZOR_EN, 1, enables replay.
- EARLY_STOP, 1, enables early termination.
- CW, 7, width of the per-frame error count.
- AW, 16, width of the accumulated counters.

Ports:
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- nClear  in  1  synchronous, active-low clear.
- Start  in  1  frame start; accepted only in IDLE.
- Razor_Error  in  1  OR of all razor flags of the half-iteration enabled in the previous cycle.
- Hard_Dec  in  FL  current hard decisions.
- b1_error  in  FL  per-bit error flags.
- Enable_Term, Enable_Odd, Enable_Even, Enable_Error_Counter  out  1 each  array strobes.
- Busy  out  1  high when state≠IDLE.
- Done  out  1  one-cycle end-of-frame pulse.
- Iter_Count  out  $clog2(MAX_ITER+1)  completed iterations in the current or last frame.
- Early_Stop  out  1  last frame stopped early.
- Frame_Errors  out  CW  popcount of b1_error for the last frame; saturates.
- Error_Total  out  AW  accumulated Frame_Errors; saturates.
- Replay_Total  out  AW  accumulated replays; saturates.
- Razor_Fail  out  1  sticky; a replay limit was exhausted while Razor_Error was still high.

## Operation

- States: IDLE, TERM, ODD, ODD_CHK, EVEN, EVEN_CHK, COUNT, DONE.
- IDLE with Start=1 → TERM. The controller clears Iter_Count, the stability counter, the previous-decision valid flag, the replay counter and Early_Stop.
- TERM: Enable_Term=1 → ODD.
- ODD: Enable_Odd=1 → ODD_CHK.
- EVEN: Enable_Even=1 → EVEN_CHK.
- ODD_CHK / EVEN_CHK, replay taken:
  - Condition: RAZOR_EN=1, Razor_Error=1 and replay counter <REPLAY_MAX.
  - Action: replay counter +1, Replay_Total +1 (saturating), return to ODD or EVEN respectively.
- ODD_CHK / EVEN_CHK, replay not taken:
  - If Razor_Error=1 at this point, set Razor_Fail.
  - Clear the replay counter.
  - ODD_CHK then → EVEN.
- EVEN_CHK on exit also completes an iteration:
  - Iter_Count +1.
  - If the valid flag is set and Hard_Dec equals the registered previous decision, the stability counter +1; otherwise it clears.
  - Register Hard_Dec and set the valid flag.
  - → COUNT if the new Iter_Count=MAX_ITER, or if EARLY_STOP=1 and the new stability count ≥STABLE_ITERS. Early_Stop is set only when the stop is caused by the stability condition with Iter_Count<MAX_ITER.
  - Otherwise → ODD.
- COUNT:
  - Enable_Error_Counter=1.
  - Frame_Errors ← min(popcount(b1_error), 2^CW−1).
  - Error_Total += that value, saturating at 2^AW−1.
  - → DONE.
- DONE: Done=1 → IDLE.
- Start outside IDLE is ignored.
- At most one enable strobe is high in any cycle.
- Priority: nReset > nClear > state logic.
  - nClear=0 forces IDLE and clears every register.
  - nClear=0 mid-frame aborts the frame with no Done pulse.

## Timing

- Reset (async) and clear values: state IDLE; all outputs 0, Razor_Fail included.
- Start sampled at cycle 0. Timeline with no replay:
  - TERM at cycle 1.
  - Iteration k occupies cycles 4k−2 … 4k+1.
  - The final iteration n ends at EVEN_CHK, cycle 4n+1.
  - COUNT at 4n+2, Done at 4n+3.
- Each replay adds 2 cycles.
- Razor_Error is sampled only in the *_CHK states. Its value elsewhere is ignored.
- Hard_Dec and b1_error are sampled only in EVEN_CHK and COUNT respectively.
- Statistics registers update on the COUNT→DONE edge and are stable while Done=1.
- A new Start is accepted in the cycle after Done (back-to-back frames: no gap beyond the IDLE cycle).

## Test plan

- Defaults, Razor_Error=0, Hard_Dec changes every iteration, b1_error with 5 bits set:
  - 8 iterations; Done at cycle 35; Iter_Count=8; Early_Stop=0.
  - Frame_Errors=5; Error_Total=5.
- Hard_Dec constant from iteration 1, STABLE_ITERS=2:
  - Stability reaches 2 after iteration 3; Done at cycle 15.
  - Iter_Count=3; Early_Stop=1.
- Razor_Error=1 in the first ODD_CHK only:
  - Enable_Odd pulses at cycles 2 and 4; Replay_Total=1.
  - Done at cycle 37.
- Razor_Error held 1 throughout, with MAX_ITER=1:
  - 3 replays per half-iteration; Razor_Fail=1; Replay_Total=6.
  - Done at cycle 19.
- b1_error all ones, FL=104, CW=7:
  - Frame_Errors=104.
  - Over 2 frames Error_Total=208. With AW=7 it saturates at 127.
- nClear=0 at cycle 10 of a frame:
  - Next cycle state IDLE, Busy=0, all counters 0, no Done pulse.
  - Start at cycle 12 begins a fresh frame normally.
